fifo_read_scheduler: RTL and testbench

//  Drains N_FIFOS standard-mode FIFOs (1-cycle rd_en->rd_data latency) into one valid/ready stream.

---
 rtl/fifo_read_scheduler_pkg.sv | 12 +
 rtl/fifo_read_scheduler_if.sv | 14 +
 rtl/fifo_read_scheduler_rr_pick.sv | 22 ++
 rtl/fifo_read_scheduler.sv | 152 +++++++++++++++
 tb/tb_fifo_read_scheduler.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_read_scheduler_pkg.sv
// Shared types and helpers for the FIFO read scheduler.
package fifo_read_sched_pkg;

    typedef enum logic {IDLE, BURST} sched_state_t;

    localparam int STAT_WIDTH = 32;

    function automatic int src_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_read_scheduler_if.sv
// Output stream of the FIFO read scheduler: tagged words under valid/ready.
interface fifo_read_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SRC_W      = 2
);
    logic [DATA_WIDTH-1:0] m_data;
    logic [SRC_W-1:0]      m_src;
    logic                  m_last;
    logic                  m_valid;
    logic                  m_ready;

    modport master (output m_data, m_src, m_last, m_valid, input  m_ready);
    modport slave  (input  m_data, m_src, m_last, m_valid, output m_ready);
endinterface

// File: rtl/fifo_read_scheduler_rr_pick.sv
// Rotate-priority encoder: first asserted req at or after ptr, wrapping; purely combinational.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_any
);
    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                gnt_idx = W'((int'(ptr) + i) % N);
                gnt_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_read_scheduler.sv
// Round-robin burst drain of N FIFOs into one tagged valid/ready stream; pop to m_valid is 2 cycles.
// Pops stall on a 2-entry output credit when m_ready is low. FIFO_READ_SCHED_STATS_EN adds per-source word counters.
module fifo_read_scheduler
    import fifo_read_sched_pkg::*;
#(
    parameter int N_FIFOS    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [N_FIFOS*DATA_WIDTH-1:0] fifo_rd_data,
    input  logic [N_FIFOS-1:0]            fifo_empty,
    output logic [N_FIFOS-1:0]            fifo_rd_en,
    fifo_read_scheduler_if.master         m_if,
`ifdef FIFO_READ_SCHED_STATS_EN
    input  logic                          stat_clear,
    output logic [N_FIFOS*STAT_WIDTH-1:0] stat_words,
`endif
    output logic                          busy
);
    localparam int            SW        = src_width(N_FIFOS);
    localparam int            BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [BW-1:0] BEAT_LIM  = BW'(MAX_BURST);

    sched_state_t          state_q;
    logic [SW-1:0]         grant_q, rr_ptr_q, pop_src_q, pick_idx, grant_nxt;
    logic [BW-1:0]         beat_q;
    logic                  pick_any, pop_q, pop_last_q;
    logic [DATA_WIDTH-1:0] buf_dat_q [2];
    logic [SW-1:0]         buf_src_q [2];
    logic [1:0]            buf_last_q;
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            occ_q;
    logic [2:0]            committed;
    logic                  grant_empty, pop_out, credit_ok, pop_now;
    logic                  end_by_cnt, end_by_empty, mark_in, mark_old;
    logic [DATA_WIDTH-1:0] wr_dat;

    rr_pick #(.N(N_FIFOS), .W(SW)) u_rr_pick (
        .req     (~fifo_empty),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    assign grant_empty  = fifo_empty[grant_q];
    assign pop_out      = (occ_q != 2'd0) && m_if.m_ready;
    // Slots already spoken for once this cycle's drain and the in-flight word settle.
    assign committed    = {1'b0, occ_q} + {2'b0, pop_q} - {2'b0, pop_out};
    assign credit_ok    = committed < 3'd2;
    assign pop_now      = (state_q == BURST) && !grant_empty && credit_ok && (beat_q < BEAT_LIM);
    assign end_by_cnt   = pop_now && (beat_q == LAST_BEAT);
    assign end_by_empty = (state_q == BURST) && grant_empty;
    assign grant_nxt    = (grant_q == SW'(N_FIFOS - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        fifo_rd_en = '0;
        if (pop_now) fifo_rd_en[grant_q] = 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            beat_q     <= '0;
            rr_ptr_q   <= '0;
            pop_q      <= 1'b0;
            pop_last_q <= 1'b0;
            pop_src_q  <= '0;
        end else begin
            pop_q      <= pop_now;
            pop_last_q <= end_by_cnt;
            if (pop_now) pop_src_q <= grant_q;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        beat_q  <= '0;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (pop_now) beat_q <= beat_q + 1'b1;
                    if (end_by_cnt || end_by_empty) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= grant_nxt;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // An empty-terminated burst tags its newest word: the one landing now, else the newest still held.
    assign wr_dat   = fifo_rd_data[int'(pop_src_q)*DATA_WIDTH +: DATA_WIDTH];
    assign mark_in  = end_by_empty && pop_q;
    assign mark_old = end_by_empty && !pop_q && (occ_q != 2'd0) && (buf_src_q[~wr_ptr_q] == grant_q);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                buf_dat_q[i] <= '0;
                buf_src_q[i] <= '0;
            end
            buf_last_q <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            occ_q      <= '0;
        end else begin
            if (pop_q) begin
                buf_dat_q[wr_ptr_q]  <= wr_dat;
                buf_src_q[wr_ptr_q]  <= pop_src_q;
                buf_last_q[wr_ptr_q] <= pop_last_q | mark_in;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (mark_old) buf_last_q[~wr_ptr_q] <= 1'b1;
            if (pop_out)  rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, pop_q} - {1'b0, pop_out};
        end
    end

    assign m_if.m_valid = (occ_q != 2'd0);
    assign m_if.m_data  = buf_dat_q[rd_ptr_q];
    assign m_if.m_src   = buf_src_q[rd_ptr_q];
    assign m_if.m_last  = buf_last_q[rd_ptr_q];
    assign busy         = (state_q == BURST) || pop_q || (occ_q != 2'd0);

`ifdef FIFO_READ_SCHED_STATS_EN
    logic [STAT_WIDTH-1:0] stat_q [N_FIFOS];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_FIFOS; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_FIFOS; i++) begin
                if (stat_clear)
                    stat_q[i] <= '0;
                else if (pop_out && (buf_src_q[rd_ptr_q] == SW'(i)))
                    stat_q[i] <= stat_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        stat_words = '0;
        for (int i = 0; i < N_FIFOS; i++) stat_words[i*STAT_WIDTH +: STAT_WIDTH] = stat_q[i];
    end
`endif

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Scoreboard bench for fifo_read_scheduler: behavioural FIFOs, expected beats queued per test, checked on accept.
module tb_fifo_read_scheduler;
    import fifo_read_sched_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 8;
    localparam int SW = 2;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [SW-1:0] src;
        logic          last;
    } beat_t;

    logic            clock  = 1'b0;
    logic            resetn = 1'b0;
    logic [N*DW-1:0] fifo_rd_data = '0;
    logic [N-1:0]    fifo_empty   = '1;
    logic [N-1:0]    fifo_rd_en;
    logic            busy;

    always #5 clock = ~clock;

    fifo_read_scheduler_if #(.DATA_WIDTH(DW), .SRC_W(SW)) m_if ();

`ifdef FIFO_READ_SCHED_STATS_EN
    logic                   stat_clear = 1'b0;
    logic [N*STAT_WIDTH-1:0] stat_words;
`endif

    fifo_read_scheduler #(.N_FIFOS(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .m_if         (m_if),
`ifdef FIFO_READ_SCHED_STATS_EN
        .stat_clear   (stat_clear),
        .stat_words   (stat_words),
`endif
        .busy         (busy)
    );

    logic [DW-1:0] fq [N][$];
    beat_t         sb [$];
    int            n_vec = 0, n_err = 0;
    int            cyc = 0, issued = 0, accepted = 0, acc_total = 0, last_acc_cyc = 0;
    int            nxt [N];
    int            ldk [N];
    logic [7:0]    tst = '0;
    bit            ready_tog = 1'b0, prev_hold = 1'b0, prev_nonlast = 1'b0;
    beat_t         prev_out = '0;
    logic [N-1:0]  rd_en_s = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] wd(input int s, input int k);
        return {8'(s), tst, 16'(k)};
    endfunction

    task automatic upd_empty();
        for (int i = 0; i < N; i++) fifo_empty[i] = (fq[i].size() == 0);
    endtask

    task automatic new_test(input int t);
        tst = 8'(t);
        for (int i = 0; i < N; i++) begin
            nxt[i] = 0;
            ldk[i] = 0;
        end
    endtask

    task automatic load(input int s, input int n);
        for (int j = 0; j < n; j++) begin
            fq[s].push_back(wd(s, ldk[s]));
            ldk[s]++;
        end
        upd_empty();
    endtask

    // One burst of n words from FIFO s, last flag on its final beat.
    task automatic plan(input int s, input int n);
        for (int j = 0; j < n; j++) begin
            sb.push_back('{dat: wd(s, nxt[s]), src: SW'(s), last: (j == n - 1)});
            nxt[s]++;
        end
    endtask

    task automatic tick();
        beat_t o, e;
        logic  acc;
        @(negedge clock);
        cyc++;
        chk("rd_en_onehot", 64'($countones(fifo_rd_en) <= 1), 64'(1));
        chk("rd_en_on_empty", 64'(fifo_rd_en & fifo_empty), 64'(0));
        chk("held_le2", 64'((issued - accepted) <= 2), 64'(1));
        o = '{dat: m_if.m_data, src: m_if.m_src, last: m_if.m_last};
        if (prev_hold) chk("hold_stable", 64'(o), 64'(prev_out));
        acc = m_if.m_valid && m_if.m_ready;
        if (acc) begin
            if (sb.size() == 0) begin
                chk("unexp_beat", 64'(sb.size()), 64'(1));
            end else begin
                e = sb.pop_front();
                chk("beat_dat", 64'(o.dat), 64'(e.dat));
                chk("beat_src", 64'(o.src), 64'(e.src));
                chk("beat_last", 64'(o.last), 64'(e.last));
            end
            if (!ready_tog && prev_nonlast) chk("burst_gap", 64'(cyc - last_acc_cyc), 64'(1));
            prev_nonlast = !o.last;
            last_acc_cyc = cyc;
        end
        prev_hold = m_if.m_valid && !m_if.m_ready;
        prev_out  = o;
        issued    += $countones(fifo_rd_en);
        accepted  += int'(acc);
        acc_total += int'(acc);
        rd_en_s   = fifo_rd_en;
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++)
            if (rd_en_s[i] && fq[i].size() > 0) fifo_rd_data[i*DW +: DW] = fq[i].pop_front();
        upd_empty();
        m_if.m_ready = ready_tog ? ~m_if.m_ready : 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_left"}, 64'(sb.size()), 64'(0));
        sb.delete();
        repeat (3) tick();
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(m_if.m_valid), 64'(0));
        chk({tag, "_data"},  64'(m_if.m_data),  64'(0));
        chk({tag, "_src"},   64'(m_if.m_src),   64'(0));
        chk({tag, "_last"},  64'(m_if.m_last),  64'(0));
        chk({tag, "_busy"},  64'(busy),         64'(0));
        chk({tag, "_rd_en"}, 64'(fifo_rd_en),   64'(0));
    endtask

    initial begin
        int n, base;
        m_if.m_ready = 1'b1;
        repeat (3) tick();
        chk_zero("rst");
        resetn = 1'b1;

        // Single short burst from FIFO0
        new_test(1);
        load(0, 3);
        plan(0, 3);
        drain("t1", 200);

        // Two deep FIFOs alternate in MAX_BURST chunks
        new_test(2);
        load(1, 20);
        load(2, 20);
        plan(1, 8); plan(2, 8); plan(1, 8); plan(2, 8); plan(1, 4); plan(2, 4);
        drain("t2", 300);

        // Backpressure every other cycle
        new_test(3);
        ready_tog = 1'b1;
        load(3, 10);
        plan(3, 8);
        plan(3, 2);
        drain("t3", 300);
        ready_tog = 1'b0;
        m_if.m_ready = 1'b1;

        // All FIFOs busy: strict rotation of full bursts
        new_test(4);
        for (int s = 0; s < N; s++) load(s, 24);
        for (int b = 0; b < 12; b++) plan(b % N, MB);
        drain("t4", 600);

        // Reset in the middle of FIFO2's burst
        new_test(5);
        load(1, 2);
        load(2, 8);
        plan(1, 2);
        plan(2, 8);
        n = 0;
        base = acc_total;
        while (acc_total - base < 5 && n < 200) begin
            tick();
            n++;
        end
        chk("t5_reach", 64'(acc_total - base), 64'(5));
        #2 resetn = 1'b0;
        #1 chk_zero("t5_rst");
        sb.delete();
        issued = 0;
        accepted = 0;
        prev_hold = 1'b0;
        prev_nonlast = 1'b0;
        repeat (2) tick();
        load(0, 2);
        plan(0, 2);
        for (int j = 0; j < fq[2].size(); j++)
            sb.push_back('{dat: fq[2][j], src: 2'd2, last: (j == fq[2].size() - 1)});
        resetn = 1'b1;
        drain("t5", 200);

`ifdef FIFO_READ_SCHED_STATS_EN
        new_test(6);
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        load(1, 5);
        plan(1, 5);
        drain("t6", 200);
        chk("stat1_count", 64'(stat_words[1*STAT_WIDTH +: STAT_WIDTH]), 64'(5));
        chk("stat0_cleared", 64'(stat_words[0 +: STAT_WIDTH]), 64'(0));
        load(1, 1);
        plan(1, 1);
        n = 0;
        while (!m_if.m_valid && n < 50) begin
            tick();
            n++;
        end
        chk("t6_valid", 64'(m_if.m_valid), 64'(1));
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        chk("stat_clear_wins", 64'(stat_words[1*STAT_WIDTH +: STAT_WIDTH]), 64'(0));
        drain("t6b", 100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
